// File: rtl/ieee754_div_prep_pkg.sv
// ieee754_div_prep_pkg
// Shared widths, IEEE754 single-precision constants, the operand class enum
// and the FIFO entry layout used by the divider operand preparation stage.
`timescale 1ns/1ps
package ieee754_div_prep_pkg;
    localparam int N  = 32;          // total word width
    localparam int M  = 23;          // fraction width
    localparam int EW = N - M - 1;   // exponent width

    localparam logic [N-1:0]  QNAN    = 32'h7FC0_0000;
    localparam logic [EW-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} cls_e;

    typedef struct packed {
        logic [N-1:0] op_a;
        logic [N-1:0] op_b;
        logic         bypass;
        logic [N-1:0] byp_result;
        logic         invalid;
        logic         divzero;
        logic         denorm;
    } entry_t;
endpackage

// File: rtl/ieee754_div_prep_if.sv
// ieee754_div_prep_if
// Operand-in / entry-out handshake bundle of the divider prep stage.
//   master : operand producer + entry consumer (drives s_valid, a, b, m_ready)
//   slave  : the prep stage itself
`timescale 1ns/1ps
interface ieee754_div_prep_if import ieee754_div_prep_pkg::*; ();
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         bypass;
    logic [N-1:0] byp_result;
    logic         flg_invalid;
    logic         flg_divzero;
    logic         flg_denorm;
    logic [15:0]  byp_count;

    modport master (
        output s_valid, a, b, m_ready,
        input  s_ready, m_valid, op_a, op_b, bypass, byp_result,
               flg_invalid, flg_divzero, flg_denorm, byp_count
    );

    modport slave (
        input  s_valid, a, b, m_ready,
        output s_ready, m_valid, op_a, op_b, bypass, byp_result,
               flg_invalid, flg_divzero, flg_denorm, byp_count
    );
endinterface

// File: rtl/ieee754_div_prep_classify.sv
// ieee754_classify
// Combinational classifier for one IEEE754 operand.
//   x       : operand word
//   cls     : ZERO / SUB / NORM / INF / NAN
//   flushed : operand with subnormals replaced by a zero of the same sign
`timescale 1ns/1ps
module ieee754_classify
    import ieee754_div_prep_pkg::*;
(
    input  logic [N-1:0] x,
    output cls_e         cls,
    output logic [N-1:0] flushed
);
    logic [EW-1:0] expo;
    logic [M-1:0]  frac;

    assign expo = x[N-2:M];
    assign frac = x[M-1:0];

    always_comb begin
        cls = NORM;
        if (expo == '0)
            cls = (frac == '0) ? ZERO : SUB;
        else if (expo == EXP_MAX)
            cls = (frac == '0) ? INF : NAN;
    end

    assign flushed = (cls == SUB) ? {x[N-1], {(N-1){1'b0}}} : x;
endmodule

// File: rtl/ieee754_div_prep.sv
// ieee754_div_prep
// Operand preparation ahead of the single-precision divider. Classifies both
// operands, resolves NaN/inf/zero/divide-by-zero locally, flushes subnormals
// and queues every result in a 2-entry in-order FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ieee754_div_prep_if (operand in, entry out,
//                saturating byp_count of bypassed entries)
`timescale 1ns/1ps
module ieee754_div_prep
    import ieee754_div_prep_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    ieee754_div_prep_if.slave        bus
);
    cls_e         cls_a, cls_b;
    logic [N-1:0] fl_a, fl_b;

    ieee754_classify u_cls_a (.x(bus.a), .cls(cls_a), .flushed(fl_a));
    ieee754_classify u_cls_b (.x(bus.b), .cls(cls_b), .flushed(fl_b));

    // Subnormals count as zero everywhere after the flush.
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_norm, sgn;
    assign a_zero = (cls_a == ZERO) || (cls_a == SUB);
    assign b_zero = (cls_b == ZERO) || (cls_b == SUB);
    assign a_inf  = (cls_a == INF);
    assign b_inf  = (cls_b == INF);
    assign a_nan  = (cls_a == NAN);
    assign b_nan  = (cls_b == NAN);
    assign a_norm = (cls_a == NORM);
    assign sgn    = bus.a[N-1] ^ bus.b[N-1];

    entry_t nxt;

    always_comb begin
        nxt            = '0;
        nxt.op_a       = fl_a;
        nxt.op_b       = fl_b;
        nxt.denorm     = (cls_a == SUB) || (cls_b == SUB);
        if (a_nan || b_nan) begin
            nxt.bypass     = 1'b1;
            nxt.byp_result = QNAN;
            nxt.invalid    = 1'b1;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            nxt.bypass     = 1'b1;
            nxt.byp_result = QNAN;
            nxt.invalid    = 1'b1;
        end else if (a_norm && b_zero) begin
            nxt.bypass     = 1'b1;
            nxt.byp_result = {sgn, EXP_MAX, {M{1'b0}}};
            nxt.divzero    = 1'b1;
        end else if (a_inf) begin
            // b is finite here: NaN and inf/inf were caught above.
            nxt.bypass     = 1'b1;
            nxt.byp_result = {sgn, EXP_MAX, {M{1'b0}}};
        end else if (a_zero || b_inf) begin
            nxt.bypass     = 1'b1;
            nxt.byp_result = {sgn, {(N-1){1'b0}}};
        end
    end

    // 2-entry FIFO
    entry_t      mem [0:1];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic [15:0] byp_cnt;
    logic        push, pop;

    assign bus.s_ready = (count != 2'd2);
    assign bus.m_valid = (count != 2'd0);
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = bus.m_valid && bus.m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            byp_cnt <= 16'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= nxt;
                wr_ptr      <= ~wr_ptr;
                if (nxt.bypass && (byp_cnt != 16'hFFFF))
                    byp_cnt <= byp_cnt + 16'd1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    entry_t head;
    assign head            = mem[rd_ptr];
    assign bus.op_a        = head.op_a;
    assign bus.op_b        = head.op_b;
    assign bus.bypass      = head.bypass;
    assign bus.byp_result  = head.byp_result;
    assign bus.flg_invalid = head.invalid;
    assign bus.flg_divzero = head.divzero;
    assign bus.flg_denorm  = head.denorm;
    assign bus.byp_count   = byp_cnt;
endmodule

// File: tb/tb_ieee754_div_prep.sv
`timescale 1ns/1ps
module tb_ieee754_div_prep;
    import ieee754_div_prep_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ieee754_div_prep_if bus ();
    ieee754_div_prep dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int byp_model = 0;

    // Reference: decide the IEEE754 outcome from value categories.
    function automatic entry_t model(input logic [31:0] a, input logic [31:0] b);
        entry_t e;
        bit az, bz, ai, bi, an, bn, s;
        az = (a[30:23] == 8'h00);               // zero or subnormal -> zero
        bz = (b[30:23] == 8'h00);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        s  = a[31] ^ b[31];
        e = '0;
        e.op_a   = az ? {a[31], 31'b0} : a;
        e.op_b   = bz ? {b[31], 31'b0} : b;
        e.denorm = (az && a[22:0] != 0) || (bz && b[22:0] != 0);
        if (an || bn || (az && bz) || (ai && bi)) begin
            e.bypass = 1; e.byp_result = 32'h7FC00000; e.invalid = 1;
        end else if (ai) begin
            e.bypass = 1; e.byp_result = {s, 31'h7F800000};
        end else if (bz) begin
            e.bypass = 1; e.byp_result = {s, 31'h7F800000}; e.divzero = 1;
        end else if (az || bi) begin
            e.bypass = 1; e.byp_result = {s, 31'b0};
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        logic        s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0: x = {s, 31'b0};
            1: x = {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
            2: x = {s, 8'hFF, 23'b0};
            3: x = {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
            default: x = {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
        return x;
    endfunction

    function automatic entry_t observe();
        entry_t e;
        e.op_a = bus.op_a; e.op_b = bus.op_b; e.bypass = bus.bypass;
        e.byp_result = bus.byp_result; e.invalid = bus.flg_invalid;
        e.divzero = bus.flg_divzero; e.denorm = bus.flg_denorm;
        return e;
    endfunction

    task automatic do_reset();
        bus.s_valid = 0; bus.a = '0; bus.b = '0; bus.m_ready = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        byp_model = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({bus.m_valid, bus.s_ready, bus.byp_count} !== {1'b0, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl got m_valid=%b s_ready=%b byp_count=%0d exp 0/1/0",
                     bus.m_valid, bus.s_ready, bus.byp_count);
        end
        n_checks++;
        if (observe() !== entry_t'(0)) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=0", observe());
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'h3FC00000, 32'h3F800000, 32'h00000000, 32'hFF800000, 32'h00000001};
        logic [31:0] vb [5] = '{32'h3F000000, 32'h00000000, 32'h80000000, 32'h40000000, 32'h3F800000};
        entry_t ex [5];
        int     bc [5] = '{0, 1, 2, 3, 4};
        ex[0] = '{op_a:32'h3FC00000, op_b:32'h3F000000, bypass:0, byp_result:0, invalid:0, divzero:0, denorm:0};
        ex[1] = '{op_a:32'h3F800000, op_b:32'h00000000, bypass:1, byp_result:32'h7F800000, invalid:0, divzero:1, denorm:0};
        ex[2] = '{op_a:32'h00000000, op_b:32'h80000000, bypass:1, byp_result:32'h7FC00000, invalid:1, divzero:0, denorm:0};
        ex[3] = '{op_a:32'hFF800000, op_b:32'h40000000, bypass:1, byp_result:32'hFF800000, invalid:0, divzero:0, denorm:0};
        ex[4] = '{op_a:32'h00000000, op_b:32'h3F800000, bypass:1, byp_result:32'h00000000, invalid:0, divzero:0, denorm:1};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.m_valid !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_empty got m_valid=%b exp 0", i, bus.m_valid);
            end
            bus.s_valid = 1; bus.a = va[i]; bus.b = vb[i]; bus.m_ready = 1;
            @(posedge clk); #1;
            bus.s_valid = 0;
            n_checks++;
            if (bus.m_valid !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d_latency got m_valid=%b exp 1", i, bus.m_valid);
            end
            n_checks++;
            if (observe() !== ex[i]) begin
                n_fail++; $display("FAIL dir%0d_entry got=%h exp=%h", i, observe(), ex[i]);
            end
            n_checks++;
            if (bus.byp_count !== 16'(bc[i])) begin
                n_fail++; $display("FAIL dir%0d_byp_count got=%0d exp=%0d", i, bus.byp_count, bc[i]);
            end
        end
        @(posedge clk); #1;
        bus.m_ready = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        int got = 0;
        bit sent2 = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); end
        @(posedge clk); #1;
        bus.m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1; bus.a = pa[i]; bus.b = pb[i];
            if (i < 2) begin @(posedge clk); #1; end
        end
        n_checks++;
        if ({bus.s_ready, bus.m_valid} !== 2'b01) begin
            n_fail++; $display("FAIL bp_full got s_ready=%b m_valid=%b exp 0/1", bus.s_ready, bus.m_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.s_ready !== 1'b0 || observe() !== model(pa[0], pb[0])) begin
            n_fail++; $display("FAIL bp_hold got s_ready=%b head=%h exp 0 head=%h",
                               bus.s_ready, observe(), model(pa[0], pb[0]));
        end
        bus.m_ready = 1;
        for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
            @(negedge clk);
            if (bus.m_valid && bus.m_ready) begin
                n_checks++;
                if (observe() !== model(pa[got], pb[got])) begin
                    n_fail++; $display("FAIL bp_order%0d got=%h exp=%h", got, observe(), model(pa[got], pb[got]));
                end
                got++;
            end
            if (bus.s_valid && bus.s_ready) sent2 = 1;
            @(posedge clk); #1;
            if (sent2) bus.s_valid = 0;
        end
        n_checks++;
        if (got != 3 || bus.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain got %0d entries m_valid=%b exp 3 entries m_valid=0", got, bus.m_valid);
        end
        bus.m_ready = 0;
    endtask

    task automatic test_back_to_back();
        entry_t q [$];
        entry_t e;
        int     cyc;
        do_reset();
        for (cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.a = rand_op(); bus.b = rand_op();
            bus.m_ready = (cyc < 20) ? 1'b1 : ($urandom_range(0, 9) < 7);
            @(negedge clk);
            n_checks++;
            if (bus.s_ready !== (q.size() != 2) || bus.m_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL b2b_flags cyc%0d got s_ready=%b m_valid=%b exp occupancy %0d",
                                   cyc, bus.s_ready, bus.m_valid, q.size());
            end
            if (bus.m_valid && bus.m_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_spurious cyc%0d got=%h exp none", cyc, observe());
                end else begin
                    e = q.pop_front();
                    if (observe() !== e) begin
                        n_fail++; $display("FAIL b2b_entry cyc%0d got=%h exp=%h", cyc, observe(), e);
                    end
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                e = model(bus.a, bus.b);
                q.push_back(e);
                if (e.bypass && byp_model < 65535) byp_model++;
            end
        end
        @(posedge clk); #1;
        bus.s_valid = 0; bus.m_ready = 1;
        for (cyc = 0; cyc < 10 && q.size() != 0; cyc++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                e = q.pop_front();
                n_checks++;
                if (observe() !== e) begin
                    n_fail++; $display("FAIL b2b_drain got=%h exp=%h", observe(), e);
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (q.size() != 0 || bus.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_leftover got %0d pending m_valid=%b exp 0", q.size(), bus.m_valid);
        end
        n_checks++;
        if (bus.byp_count !== 16'(byp_model)) begin
            n_fail++; $display("FAIL b2b_byp_count got=%0d exp=%0d", bus.byp_count, byp_model);
        end
        bus.m_ready = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        bus.m_ready = 0; bus.s_valid = 1;
        bus.a = 32'h3F800000; bus.b = 32'h00000000;
        @(posedge clk); #1;
        bus.a = 32'h7F800001; bus.b = 32'h3F800000;
        @(posedge clk); #1;
        bus.s_valid = 0;
        n_checks++;
        if ({bus.m_valid, bus.s_ready, bus.byp_count} !== {1'b1, 1'b0, 16'd2}) begin
            n_fail++; $display("FAIL rmid_full got m_valid=%b s_ready=%b byp_count=%0d exp 1/0/2",
                               bus.m_valid, bus.s_ready, bus.byp_count);
        end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({bus.m_valid, bus.s_ready, bus.byp_count} !== {1'b0, 1'b1, 16'd0} || observe() !== entry_t'(0)) begin
            n_fail++; $display("FAIL rmid_async got m_valid=%b s_ready=%b byp_count=%0d data=%h exp 0/1/0/0",
                               bus.m_valid, bus.s_ready, bus.byp_count, observe());
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.byp_count !== 16'd0) begin
            n_fail++; $display("FAIL rmid_after got m_valid=%b byp_count=%0d exp 0/0", bus.m_valid, bus.byp_count);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ieee754_div_prep.md
# ieee754_div_prep

Operand preparation stage sitting directly upstream of the single-precision divider. Accepts operand pairs over a valid/ready handshake, classifies both operands, and resolves IEEE754 special cases (NaN, infinity, zero, divide-by-zero, subnormal flush) locally. Normal/normal pairs go to the divider unchanged. All results are held in a 2-entry output FIFO, so the divider-side consumer can stall without losing data.

## Interface
- N, 32, total word width
- M, 23, mantissa (fraction) width; exponent width is N-M-1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  operand pair valid
- s_ready  out  1  stage can accept a pair
- a  in  N  dividend, IEEE754
- b  in  N  divisor, IEEE754
- m_valid  out  1  output entry valid
- m_ready  in  1  consumer accepts entry
- op_a  out  N  dividend to divider (subnormal flushed to signed zero)
- op_b  out  N  divisor to divider (same flush)
- bypass  out  1  1 = byp_result is final and the divider result must be ignored
- byp_result  out  N  special-case result
- flg_invalid  out  1  invalid-operation flag for this entry
- flg_divzero  out  1  divide-by-zero flag for this entry
- flg_denorm  out  1  at least one subnormal operand was flushed
- byp_count  out  16  saturating count of bypassed entries

## Operation
- Transfer in: s_valid & s_ready on a clock edge. Transfer out: m_valid & m_ready on a clock edge.
- Classification per operand, with E = exponent field and F = fraction:
  - zero: E==0, F==0
  - subnormal: E==0, F!=0; treated as signed zero, sets flg_denorm
  - inf: E==all-ones, F==0
  - NaN: E==all-ones, F!=0
  - normal: all other encodings
- Result sign s = a[N-1]^b[N-1]. Rules are applied in this priority order:
  1. Either operand NaN -> 0x7FC00000, invalid=1.
  2. 0/0 or inf/inf -> 0x7FC00000, invalid=1.
  3. Finite nonzero / 0 -> {s, inf}, divzero=1.
  4. inf / finite -> {s, inf}.
  5. 0 / non-NaN, or finite / inf -> {s, zero}.
  6. Otherwise bypass=0, byp_result=0, and flags are 0 except flg_denorm.
- Any rule 1–5 hit sets bypass=1. op_a and op_b are always stored, flush applied.
- FIFO: depth 2, occupancy count 0..2, strict in-order.
  - s_ready = (count != 2). m_valid = (count != 0).
  - Push and pop in the same cycle at count 1 leaves count at 1. At count 0 only a push can occur. At count 2 only a pop can occur.
- byp_count increments on each input transfer with bypass=1 and saturates at 0xFFFF.

## Timing
- Reset (async assert, sync-safe deassert):
  - count=0, m_valid=0, s_ready=1, byp_count=0.
  - All data and flag outputs read 0.
- Latency: a pair accepted at edge k is presented with m_valid=1 after edge k, when the FIFO was empty.
- Throughput: 1 pair/cycle while m_ready=1.
- Output stability: entry outputs stay stable while m_valid=1 and m_ready=0.
- Classification is combinational on a/b and is registered at push. There is no combinational path from m_ready to outputs other than s_ready via count.
- Reset mid-operation: all stored entries are discarded. No partial entry survives.

## Structure
- Shared package holds:
  - widths N, M, and the exponent width
  - constants QNAN=0x7FC00000, EXP_MAX=all-ones
  - class enum {ZERO, SUB, NORM, INF, NAN}
  - entry struct {op_a, op_b, bypass, byp_result, invalid, divzero, denorm}
- One sub-module, ieee754_classify: combinational per-operand classifier. Instantiate it twice.
- FIFO storage and control are in this block.

## Test plan
- a=0x3FC00000, b=0x3F000000, m_ready=1 -> one cycle later m_valid=1, op_a/op_b unchanged, bypass=0, all flags 0.
- a=0x3F800000, b=0x00000000 -> byp_result=0x7F800000, bypass=1, flg_divzero=1, byp_count=1.
- a=0x00000000, b=0x80000000 -> byp_result=0x7FC00000, flg_invalid=1. a=0xFF800000, b=0x40000000 -> byp_result=0xFF800000, no flags.
- a=0x00000001, b=0x3F800000 -> op_a=0x00000000, flg_denorm=1, bypass=1, byp_result=0x00000000.
- m_ready=0, drive 3 pairs back-to-back -> s_ready drops after the 2nd. Release m_ready -> outputs in order, third pair accepted, no loss or duplication.
- Fill the FIFO with 2 entries, then pulse rst_n low mid-cycle -> immediately m_valid=0, s_ready=1, byp_count=0.
